// File: rtl/display_color_pkg.sv
// Shared mode encodings and mode-decoding helpers for the display colour pipeline.
package display_color_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_BRIGHT = 2'd1;
  localparam logic [1:0] MODE_GAMMA  = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  function automatic logic uses_gamma(input logic [1:0] m);
    return m == MODE_GAMMA;
  endfunction

  // The reserved encoding falls through to plain bypass.
  function automatic logic uses_bright(input logic [1:0] m);
    return (m == MODE_BRIGHT) || (m == MODE_GAMMA);
  endfunction

endpackage

// File: rtl/display_color_channel.sv
// Per-channel arithmetic: a gamma approximation feeding stage 1, and brightness scaling
// plus width conversion feeding stage 2. Purely combinational; the pipeline owns the registers.
module display_color_channel
  import display_color_pkg::*;
#(
  parameter int bitwidth   = 8,
  parameter int cyclewidth = 8
) (
  input  logic [1:0]            g_mode,
  input  logic [bitwidth-1:0]   c,
  output logic [bitwidth-1:0]   g,
  input  logic [1:0]            s_mode,
  input  logic [bitwidth-1:0]   brightness,
  input  logic [bitwidth-1:0]   g_in,
  output logic [cyclewidth-1:0] q
);

  localparam int pw = 2 * bitwidth;
  localparam int sw = 2 * bitwidth + 1;

  logic [pw-1:0]       sq_next;
  logic [sw-1:0]       sc_next;
  logic [bitwidth-1:0] s_next;
  logic                unused_bits;

  // c*(c+1) keeps full scale at full scale while staying inside 2*bitwidth bits.
  always_comb begin
    sq_next = pw'(c) * (pw'(c) + pw'(1));
    g       = uses_gamma(g_mode) ? sq_next[pw-1:bitwidth] : c;
  end

  // brightness+1 makes the all-ones setting an exact unity gain.
  always_comb begin
    sc_next = sw'(g_in) * (sw'(brightness) + sw'(1));
    s_next  = uses_bright(s_mode) ? sc_next[bitwidth +: bitwidth] : g_in;
  end

  // Output bit gi reads input bits MSB-first, wrapping, which covers widen, narrow and equal.
  for (genvar gi = 0; gi < cyclewidth; gi++) begin : g_conv
    localparam int src = bitwidth - 1 - ((cyclewidth - 1 - gi) % bitwidth);
    assign q[gi] = s_next[src];
  end

  assign unused_bits = ^{sq_next[bitwidth-1:0], sc_next[sw-1], sc_next[bitwidth-1:0], s_next};

endmodule

// File: rtl/display_color_pipeline.sv
// Two-stage valid/ready colour pipeline: stage 1 registers gamma-corrected channels, stage 2
// registers scaled and width-converted channels that drive the output port directly.
module display_color_pipeline
  import display_color_pkg::*;
#(
  parameter int segments   = 2,
  parameter int channels   = 3,
  parameter int bitwidth   = 8,
  parameter int cyclewidth = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [segments*channels*bitwidth-1:0]     in_pixel,
  input  logic [1:0]                                mode,
  input  logic [bitwidth-1:0]                       brightness,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [segments*channels*cyclewidth-1:0]   out_pixel
);

  localparam int lanes = segments * channels;

  if (cyclewidth < 1 || cyclewidth > 16) begin : g_bad_cyclewidth
    $error("display_color_pipeline: cyclewidth must be within 1..16");
  end

  logic                        s1_valid_reg;
  logic [1:0]                  s1_mode_reg;
  logic [bitwidth-1:0]         s1_bright_reg;
  logic [lanes*bitwidth-1:0]   s1_pix_reg;
  logic                        s2_valid_reg;
  logic [lanes*cyclewidth-1:0] s2_pix_reg;

  logic [lanes*bitwidth-1:0]   g_next;
  logic [lanes*cyclewidth-1:0] q_next;
  logic                        s1_adv;
  logic                        s2_adv;

  // Stage 2 frees up whenever it is empty or its beat leaves this cycle.
  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = s1_valid_reg && s2_adv;
  assign in_ready = !s1_valid_reg || s1_adv;

  // Stage 1 uses the incoming mode; stage 2 uses the mode captured with the beat.
  for (genvar gi = 0; gi < lanes; gi++) begin : g_lane
    display_color_channel #(
      .bitwidth   (bitwidth),
      .cyclewidth (cyclewidth)
    ) u_channel (
      .g_mode     (mode),
      .c          (in_pixel[gi*bitwidth +: bitwidth]),
      .g          (g_next[gi*bitwidth +: bitwidth]),
      .s_mode     (s1_mode_reg),
      .brightness (s1_bright_reg),
      .g_in       (s1_pix_reg[gi*bitwidth +: bitwidth]),
      .q          (q_next[gi*cyclewidth +: cyclewidth])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_mode_reg   <= MODE_BYPASS;
      s1_bright_reg <= '0;
      s1_pix_reg    <= '0;
      s2_valid_reg  <= 1'b0;
      s2_pix_reg    <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          s1_pix_reg    <= g_next;
          s1_mode_reg   <= mode;
          s1_bright_reg <= brightness;
        end
      end
      // Data only moves with a valid beat so a stalled output never changes underneath.
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_pix_reg <= q_next;
        end
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_pixel = s2_pix_reg;

endmodule

// File: doc/display_color_pipeline.md
DISPLAY_COLOR_PIPELINE -- requirements
Module: display_color_pipeline

Interface
REQ-001 SHALL have parameter segments, default 2: number of pixels (display segments) carried per beat.
REQ-002 SHALL have parameter channels, default 3: colour channels per pixel, packed R at MSB.
REQ-003 SHALL have parameter bitwidth, default 8: input bits per channel.
REQ-004 SHALL have parameter cyclewidth, default 8: output bits per channel; legal range 1..16.
REQ-005 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1: in_pixel, mode and brightness are valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts the beat this cycle.
REQ-009 SHALL have port in_pixel, input, segments*channels*bitwidth: input pixels, segment 0 at LSB.
REQ-010 SHALL have port mode, input, 2: 0 bypass, 1 brightness, 2 gamma+brightness, 3 reserved.
REQ-011 SHALL have port brightness, input, bitwidth: global scale; all-ones means unity.
REQ-012 SHALL have port out_valid, output, 1: out_pixel holds a converted beat.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts the output beat.
REQ-014 SHALL have port out_pixel, output, segments*channels*cyclewidth: converted pixels, same packing as input.

Function
REQ-015 SHALL transfer a beat on a port when valid and ready are both high on a rising clk edge.
REQ-016 SHALL sample mode and brightness together with in_pixel, so each beat uses its own settings.
REQ-017 SHALL implement two registered stages: S1 gamma, S2 brightness plus width conversion.
REQ-018 SHALL give latency of exactly 2 cycles from input transfer to out_valid with out_ready held high.
REQ-019 SHALL sustain one beat per cycle throughput with out_ready high.
REQ-020 SHALL advance stage k when it is empty or its downstream stage advances.
REQ-021 SHALL drive in_ready = !S1_valid | S1_advance, combinationally from out_ready; no beat is dropped or duplicated.
REQ-022 SHALL hold out_pixel and out_valid stable while out_valid & !out_ready.
REQ-023 SHALL compute gamma (mode 2) as g = (c*(c+1)) >> bitwidth, with a 2*bitwidth-bit intermediate; otherwise g = c.
REQ-024 SHALL compute brightness (modes 1, 2) as s = (g*(brightness+1)) >> bitwidth, with a (2*bitwidth+1)-bit intermediate; in mode 0, s = g.
REQ-025 SHALL treat mode 3 as mode 0.
REQ-026 SHALL widen when cyclewidth > bitwidth by MSB-first bit replication, so all-ones maps to all-ones and zero to zero.
REQ-027 SHALL narrow when cyclewidth < bitwidth by taking the cyclewidth MSBs.
REQ-028 SHALL apply identical arithmetic independently to every channel of every segment.

Reset
REQ-029 SHALL clear S1_valid and S2_valid asynchronously while rst_n is low, so out_valid = 0 and in_ready = 1 immediately.
REQ-030 SHALL reset out_pixel and all stage data registers to zero.
REQ-031 SHALL discard beats in flight when reset is asserted mid-stream, with no output of them after release.
REQ-032 SHALL accept input on the first rising edge after rst_n deasserts.

Structure
REQ-033 SHALL place the mode encodings (MODE_BYPASS, MODE_BRIGHT, MODE_GAMMA) in shared package display_color_pkg.
REQ-034 SHALL place per-channel arithmetic in sub-module display_color_channel (gamma, scale, width convert), instantiated segments*channels times.
REQ-035 SHALL keep the handshake and valid logic in display_color_pipeline only.

Verification
REQ-036 SHALL verify bypass: mode 0, in_pixel {24'h000000,24'hffffff}, out_ready=1 -> out_pixel identical 2 cycles later; repeat for ffff00, ff00ff, 00ffff, 000000.
REQ-037 SHALL verify gamma: mode 2, brightness ff, channel 80 -> 40; ff -> ff; 00 -> 00; 01 -> 00.
REQ-038 SHALL verify brightness: mode 1, brightness 7f, channel ff -> 7f; brightness 00, channel ff -> 00; brightness ff -> identity.
REQ-039 SHALL verify backpressure: stream of 4 beats with out_ready low for 3 cycles mid-stream -> in_ready low once both stages are full, output held stable, all 4 beats delivered in order exactly once.
REQ-040 SHALL verify width: cyclewidth=12, mode 0, channel ff -> fff; 80 -> 808; cyclewidth=4, channel a5 -> a.
REQ-041 SHALL verify reset: rst_n pulsed low with 2 beats in flight -> out_valid 0 asynchronously and stays 0 until a new beat is accepted; in_ready 1 during reset.
